// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 32;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Two's-complement magnitude for signed operations, raw value otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    mag = (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/multdiv_passo.sv
// One iteration of the shared datapath: shift-add for multiply,
// shift/trial-subtract/restore for divide.
module multdiv_passo
  import multdiv_pkg::*;
(
  input  logic             is_div,
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] diff;

  // Next accumulator/remainder and low word/quotient for one step.
  always_comb begin
    sum  = {1'b0, r_i[WIDTH-1:0]} + (q_i[0] ? {1'b0, m_i} : '0);
    r_sh = {r_i, q_i[WIDTH-1]};
    diff = r_sh - {2'b00, m_i};
    if (is_div) begin
      if (diff[WIDTH+1]) begin
        r_o = r_sh[WIDTH:0];
        q_o = {q_i[WIDTH-2:0], 1'b0};
      end else begin
        r_o = diff[WIDTH:0];
        q_o = {q_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      // carry enters the top of the 64-bit accumulator on the right shift
      r_o = {1'b0, sum[WIDTH:1]};
      q_o = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/controle_multdiv.sv
// Multiply/divide sequencer with HI/LO registers and mthi/mtlo access.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// RUN   | 32 datapath steps, step counter 0..31
// FIX   | sign correction and HI/LO write-back
module controle_multdiv
  import multdiv_pkg::state_e, multdiv_pkg::IDLE, multdiv_pkg::RUN, multdiv_pkg::FIX,
         multdiv_pkg::OP_MULT, multdiv_pkg::OP_DIV, multdiv_pkg::OP_DIVU,
         multdiv_pkg::STEPS, multdiv_pkg::CNT_W, multdiv_pkg::mag;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sgn_lo_q, sgn_lo_d;     // product / quotient sign
  logic               sgn_hi_q, sgn_hi_d;     // remainder sign
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH:0]     r_q, r_d, r_nxt;
  logic [WIDTH-1:0]   q_q, q_d, q_nxt;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic               start_ok, is_div_in, signed_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign start_ok  = start && (state_q == IDLE);
  assign is_div_in = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_in = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = mag(a, signed_in);
  assign mag_b     = mag(b, signed_in);

  multdiv_passo u_passo (
    .is_div (is_div_q),
    .r_i    (r_q),
    .q_i    (q_q),
    .m_i    (m_q),
    .r_o    (r_nxt),
    .q_o    (q_nxt)
  );

  // Sign-corrected results used by FIX. With a zero divisor the remainder
  // register ends up holding |a|, so the remainder correction restores raw a.
  always_comb begin
    prod     = {r_q[WIDTH-1:0], q_q};
    prod_fix = sgn_lo_q ? -prod : prod;
    quo_fix  = sgn_lo_q ? -q_q : q_q;
    rem_fix  = sgn_hi_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
  end

  // Next-state, datapath load and HI/LO update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    sgn_lo_d   = sgn_lo_q;
    sgn_hi_d   = sgn_hi_q;
    dbz_pend_d = dbz_pend_q;
    r_d        = r_q;
    q_d        = q_q;
    m_d        = m_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = RUN;
          cnt_d      = '0;
          is_div_d   = is_div_in;
          sgn_lo_d   = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn_hi_d   = signed_in & is_div_in & a[WIDTH-1];
          dbz_pend_d = is_div_in && (b == '0);
          dbz_d      = 1'b0;
          m_d        = is_div_in ? mag_b : mag_a;
          q_d        = is_div_in ? mag_a : mag_b;
          r_d        = '0;
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      RUN: begin
        r_d   = r_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d  = dbz_pend_q ? '1 : quo_fix;
          hi_d  = rem_fix;
          dbz_d = dbz_pend_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sgn_lo_q   <= 1'b0;
      sgn_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      sgn_lo_q   <= sgn_lo_d;
      sgn_hi_q   <= sgn_hi_d;
      dbz_pend_q <= dbz_pend_d;
      r_q        <= r_d;
      q_q        <= q_d;
      m_q        <= m_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
